four_input_stim_gen: RTL

//  Clocked stimulus generator driving the a/b/c/d inputs of the four-input gate stages.

---
 rtl/four_input_stim_gen_pkg.sv | 18 +
 rtl/four_input_stim_gen_step_prescaler.sv | 27 ++
 rtl/four_input_stim_gen.sv | 106 ++++++++++
 3 files changed

// File: rtl/four_input_stim_gen_pkg.sv
// rtl/four_input_stim_gen_pkg.sv - shared types and pattern map for the four-input stimulus generator
package four_input_stim_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {BIN, GRAY, WALK, DESC} mode_e;

  localparam int PAT_COUNT = 16;

  function automatic logic [3:0] pattern_of(input mode_e m, input logic [3:0] i);
    case (m)
      BIN:     return i;
      GRAY:    return i ^ (i >> 1);
      WALK:    return 4'b0001 << i[1:0];
      default: return 4'd15 - i;
    endcase
  endfunction

endpackage

// File: rtl/four_input_stim_gen_step_prescaler.sv
// rtl/four_input_stim_gen_step_prescaler.sv - down-counter that ticks on the last cycle of each pattern hold
module step_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // div is always >= 1 here; clr keeps the counter preloaded so the first hold is full length
  assign tick = (cnt == '0) && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= div - DIV_W'(1);
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/four_input_stim_gen.sv
// rtl/four_input_stim_gen.sv - restartable 16-pattern a/b/c/d stimulus sequencer with loop count and done pulse
module four_input_stim_gen
  import four_input_stim_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int LOOP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  step_div,
  input  logic [LOOP_W-1:0] num_loops,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              step_strobe,
  output logic [3:0]        pattern_idx,
  output logic              busy,
  output logic              done
);

  state_e            state;
  mode_e             mode_q;
  logic [DIV_W-1:0]  div_q;
  logic [LOOP_W-1:0] loops_q;
  logic [LOOP_W-1:0] loop_cnt;
  logic [DIV_W-1:0]  div_in;
  logic [DIV_W-1:0]  div_sel;
  logic [3:0]        next_idx;
  logic              tick;
  logic              last_step;

  assign div_in    = (step_div == '0) ? DIV_W'(1) : step_div;
  // Outside RUN the prescaler preloads from the live input so the first hold matches the latched value
  assign div_sel   = (state == RUN) ? div_q : div_in;
  assign next_idx  = pattern_idx + 4'd1;
  assign last_step = tick && (pattern_idx == 4'(PAT_COUNT - 1)) && (loop_cnt == loops_q);

  step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != RUN),
    .div  (div_sel),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mode_q       <= BIN;
      div_q        <= '0;
      loops_q      <= '0;
      loop_cnt     <= '0;
      pattern_idx  <= '0;
      {d, c, b, a} <= '0;
      step_strobe  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state        <= RUN;
            mode_q       <= mode_e'(mode);
            div_q        <= div_in;
            loops_q      <= num_loops;
            loop_cnt     <= '0;
            pattern_idx  <= '0;
            {d, c, b, a} <= pattern_of(mode_e'(mode), 4'd0);
            step_strobe  <= 1'b1;
            busy         <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state        <= IDLE;
            busy         <= 1'b0;
            pattern_idx  <= '0;
            {d, c, b, a} <= '0;
          end else if (last_step) begin
            state        <= DONE;
            done         <= 1'b1;
            busy         <= 1'b0;
            pattern_idx  <= '0;
            {d, c, b, a} <= '0;
          end else if (tick) begin
            if (pattern_idx == 4'(PAT_COUNT - 1)) begin
              loop_cnt <= loop_cnt + LOOP_W'(1);
            end
            pattern_idx  <= next_idx;
            {d, c, b, a} <= pattern_of(mode_q, next_idx);
            step_strobe  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
